// File: rtl/smd_pad_scheduler_if.sv
// Host/responder snapshot bus for smd_pad_scheduler: host-side valid/ready
// snapshot input and the committed snapshot toward the six-button responder.
interface smd_pad_scheduler_if;
    logic [11:0] in_btn;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] out_btn;
    logic        commit;

    modport master (
        output in_btn, in_valid,
        input  in_ready, out_btn, commit
    );

    modport slave (
        input  in_btn, in_valid,
        output in_ready, out_btn, commit
    );
endinterface

// File: rtl/smd_pad_scheduler.sv
// Holds host button snapshots and commits them to the Mega Drive responder only
// while p7 is quiet. Optional macro SMD_SOCD_EN cleans opposing directions at commit.
module smd_pad_scheduler #(
    parameter logic [11:0] QUIET_CYCLES = 12'd255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 p7,
    smd_pad_scheduler_if.slave   bus,
    output logic                 busy,
    output logic                 three_button_mode,
    output logic                 mode_locked
);

    localparam logic [0:0] ST_QUIET  = 1'b0;
    localparam logic [0:0] ST_ACTIVE = 1'b1;

    logic [2:0]  p7_pipe;
    logic        p7_edge;
    logic [11:0] cnt_q;
    logic [0:0]  state_q;
    logic [11:0] pend_btn;
    logic        pend_valid;
    logic [11:0] out_q;
    logic        accept;
    logic        do_commit;
    logic [11:0] commit_btn;

    // [0],[1] synchronize p7; [2] is the history flop for edge detection
    always_ff @(posedge clk) begin
        if (rst) p7_pipe <= 3'b111;
        else     p7_pipe <= {p7_pipe[1:0], p7};
    end

    assign p7_edge = p7_pipe[1] ^ p7_pipe[2];

    always_ff @(posedge clk) begin
        if (rst)             cnt_q <= 12'd0;
        else if (p7_edge)    cnt_q <= QUIET_CYCLES;
        else if (cnt_q != 0) cnt_q <= cnt_q - 12'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_QUIET;
        end else begin
            case (state_q)
                ST_QUIET:  if (p7_edge) state_q <= ST_ACTIVE;
                // <= 1 rather than == 1 so a zero QUIET_CYCLES cannot strand ACTIVE
                ST_ACTIVE: if (!p7_edge && cnt_q <= 12'd1) state_q <= ST_QUIET;
                default:   state_q <= ST_QUIET;
            endcase
        end
    end

    assign busy = (state_q == ST_ACTIVE);

    // Decision uses the registered state, so an edge arriving now does not block it
    assign do_commit = (state_q == ST_QUIET) && pend_valid;
    assign accept    = bus.in_valid && !pend_valid;

    always_comb begin
        commit_btn = pend_btn;
`ifdef SMD_SOCD_EN
        if (!pend_btn[0] && !pend_btn[1]) commit_btn[1:0] = 2'b11;
        if (!pend_btn[2] && !pend_btn[3]) commit_btn[3:2] = 2'b11;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_valid        <= 1'b0;
            pend_btn          <= 12'hFFF;
            out_q             <= 12'hFFF;
            three_button_mode <= 1'b0;
            mode_locked       <= 1'b0;
        end else begin
            if (do_commit) begin
                out_q      <= commit_btn;
                pend_valid <= 1'b0;
            end else if (accept) begin
                pend_btn   <= bus.in_btn;
                pend_valid <= 1'b1;
            end
            if (accept && !mode_locked) begin
                three_button_mode <= !bus.in_btn[11];
                mode_locked       <= 1'b1;
            end
        end
    end

    assign bus.in_ready = !pend_valid;
    assign bus.out_btn  = out_q;
    assign bus.commit   = do_commit;

endmodule

// File: tb/tb_smd_pad_scheduler.sv
// Bench for smd_pad_scheduler: directed vector table, hand-written p7 burst
// sequences and random traffic, all checked against a window-based model.
module tb_smd_pad_scheduler;

    localparam logic [11:0] Q  = 12'd48;
    localparam int          QI = 48;
`ifdef SMD_SOCD_EN
    localparam logic [11:0] OUT_FF0 = 12'hFFF;
    localparam logic [11:0] OUT_FFC = 12'hFFF;
`else
    localparam logic [11:0] OUT_FF0 = 12'hFF0;
    localparam logic [11:0] OUT_FFC = 12'hFFC;
`endif

    logic clk = 1'b0;
    logic rst;
    logic p7;
    logic busy, tbm, locked;

    always #5 clk = ~clk;

    smd_pad_scheduler_if bus ();

    smd_pad_scheduler #(.QUIET_CYCLES(Q)) dut (
        .clk               (clk),
        .rst               (rst),
        .p7                (p7),
        .bus               (bus),
        .busy              (busy),
        .three_button_mode (tbm),
        .mode_locked       (locked)
    );

    int tests = 0;
    int fails = 0;

    // Model: busy iff the last detected edge lies 1..Q cycles in the past
    int          k;
    int          last_edge;
    bit          pend;
    logic [11:0] pend_val;
    logic [11:0] m_out;
    bit          m_mode, m_locked;
    logic        h0, h1, h2;

    typedef struct {
        bit          r, v;
        logic [11:0] b;
        bit          e_commit, e_ready, e_busy, e_mode, e_locked;
        logic [11:0] e_out;
    } vec_t;

    vec_t vecs[12];

    function automatic logic [11:0] clean(input logic [11:0] raw);
        logic [11:0] x;
        x = raw;
`ifdef SMD_SOCD_EN
        if (x[1:0] == 2'b00) x[1:0] = 2'b11;
        if (x[3:2] == 2'b00) x[3:2] = 2'b11;
`endif
        return x;
    endfunction

    function automatic bit m_busy(input int c);
        return (c - last_edge >= 1) && (c - last_edge <= QI);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, k, act, exp);
        end
    endtask

    task automatic step(input bit r, input bit v, input logic [11:0] b, input logic p);
        bit bp, e, cm, acc;
        bus.in_valid = v;
        bus.in_btn   = b;
        rst          = r;
        p7           = p;
        @(posedge clk);
        if (r) begin
            pend = 0; m_out = 12'hFFF; m_mode = 0; m_locked = 0;
            h0 = 1'b1; h1 = 1'b1; h2 = 1'b1;
            last_edge = -1000000;
        end else begin
            bp  = m_busy(k);
            e   = (h1 != h2);
            cm  = pend && !bp;
            acc = v && !pend;
            if (e) last_edge = k;
            if (cm) begin
                m_out = clean(pend_val);
                pend  = 0;
            end
            if (acc) begin
                pend     = 1;
                pend_val = b;
                if (!m_locked) begin
                    m_mode   = !b[11];
                    m_locked = 1;
                end
            end
            h2 = h1; h1 = h0; h0 = p;
        end
        k++;
        @(negedge clk);
        chk("m_commit", int'(bus.commit),   int'(pend && !m_busy(k)));
        chk("m_busy",   int'(busy),         int'(m_busy(k)));
        chk("m_ready",  int'(bus.in_ready), int'(!pend));
        chk("m_out",    int'(bus.out_btn),  int'(m_out));
        chk("m_mode",   int'(tbm),          int'(m_mode));
        chk("m_locked", int'(locked),       int'(m_locked));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        pv;
        bit          rr, vv;
        logic [11:0] bb;
        int          n, ncommit;
        logic [11:0] old_out;

        k = 0; last_edge = -1000000; pend = 0; pend_val = 12'hFFF;
        m_out = 12'hFFF; m_mode = 0; m_locked = 0; h0 = 1; h1 = 1; h2 = 1;
        rst = 1'b1; p7 = 1'b1; bus.in_valid = 1'b0; bus.in_btn = 12'hFFF;
        pv = 1'b1;

        //           r     v     b        commit ready busy mode  lock  out
        vecs[0]  = '{1'b1, 1'b0, 12'hFFF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 12'hFFF};
        vecs[1]  = '{1'b0, 1'b1, 12'hFFE, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 12'hFFF};
        vecs[2]  = '{1'b0, 1'b0, 12'hFFF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 12'hFFE};
        vecs[3]  = '{1'b0, 1'b1, 12'hFF0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 12'hFFE};
        vecs[4]  = '{1'b0, 1'b0, 12'hFFF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, OUT_FF0};
        vecs[5]  = '{1'b0, 1'b1, 12'hFFC, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, OUT_FF0};
        vecs[6]  = '{1'b0, 1'b0, 12'hFFF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, OUT_FFC};
        vecs[7]  = '{1'b1, 1'b0, 12'hFFF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 12'hFFF};
        vecs[8]  = '{1'b0, 1'b1, 12'h7FF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 12'hFFF};
        vecs[9]  = '{1'b0, 1'b0, 12'hFFF, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 12'h7FF};
        vecs[10] = '{1'b0, 1'b1, 12'hFFF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 12'h7FF};
        vecs[11] = '{1'b0, 1'b0, 12'hFFF, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 12'hFFF};

        step(1, 0, 12'hFFF, pv);
        for (int i = 0; i < 12; i++) begin
            step(vecs[i].r, vecs[i].v, vecs[i].b, pv);
            chk($sformatf("vec%0d_commit", i), int'(bus.commit),   int'(vecs[i].e_commit));
            chk($sformatf("vec%0d_ready", i),  int'(bus.in_ready), int'(vecs[i].e_ready));
            chk($sformatf("vec%0d_busy", i),   int'(busy),         int'(vecs[i].e_busy));
            chk($sformatf("vec%0d_mode", i),   int'(tbm),          int'(vecs[i].e_mode));
            chk($sformatf("vec%0d_locked", i), int'(locked),       int'(vecs[i].e_locked));
            chk($sformatf("vec%0d_out", i),    int'(bus.out_btn),  int'(vecs[i].e_out));
        end

        // Burst: 8 p7 edges 40 cycles apart, snapshot offered after the 2nd edge
        step(1, 0, 12'hFFF, pv);
        for (int j = 0; j < 5; j++) step(0, 0, 12'hFFF, pv);
        old_out = bus.out_btn;
        for (int t = 0; t < 8; t++) begin
            pv = !pv;
            step(0, 0, 12'hFFF, pv);
            if (t < 7) begin
                for (int j = 1; j < 40; j++) begin
                    if (t == 1 && j == 5) step(0, 1, 12'hFF0, pv);
                    else if (t == 1 && j == 6) begin
                        step(0, 1, 12'h0AB, pv);
                        chk("burst_ready_low", int'(bus.in_ready), 0);
                    end else step(0, 0, 12'hFFF, pv);
                    if (bus.commit) chk("burst_early_commit", 1, 0);
                end
            end
        end
        n = 0;
        while (!bus.commit && n < 300) begin
            n++;
            step(0, 0, 12'hFFF, pv);
        end
        chk("burst_commit_delay", n, QI + 2);
        chk("burst_out_held", int'(bus.out_btn), int'(old_out));
        step(0, 0, 12'hFFF, pv);
        chk("burst_out_new", int'(bus.out_btn), int'(OUT_FF0));
        chk("burst_ready_back", int'(bus.in_ready), 1);

        // Edge reaches the detector in the same cycle as a QUIET commit
        for (int j = 0; j < QI + 5; j++) step(0, 0, 12'hFFF, pv);
        pv = !pv;
        step(0, 0, 12'hFFF, pv);
        step(0, 1, 12'hABC, pv);
        chk("same_commit", int'(bus.commit), 1);
        chk("same_busy_now", int'(busy), 0);
        step(0, 0, 12'hFFF, pv);
        chk("same_busy_next", int'(busy), 1);
        chk("same_out", int'(bus.out_btn), int'(clean(12'hABC)));
        n = 1;
        while (busy && n < 300) begin
            n++;
            step(0, 0, 12'hFFF, pv);
        end
        chk("same_busy_len", n, QI + 1);

        // Reset during ACTIVE with a snapshot pending
        pv = !pv;
        step(0, 0, 12'hFFF, pv);
        for (int j = 0; j < 4; j++) step(0, 0, 12'hFFF, pv);
        step(0, 1, 12'h123, pv);
        step(0, 0, 12'hFFF, pv);
        chk("rst_pre_busy", int'(busy), 1);
        chk("rst_pre_pending", int'(bus.in_ready), 0);
        step(1, 0, 12'hFFF, pv);
        chk("rst_out", int'(bus.out_btn), 12'hFFF);
        chk("rst_ready", int'(bus.in_ready), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_commit", int'(bus.commit), 0);
        ncommit = 0;
        for (int j = 0; j < QI + 10; j++) begin
            step(0, 0, 12'hFFF, pv);
            if (bus.commit) ncommit++;
        end
        chk("rst_no_commit", ncommit, 0);
        chk("rst_out_after", int'(bus.out_btn), 12'hFFF);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            rr = ($urandom_range(0, 499) == 0);
            vv = ($urandom_range(0, 2) == 0);
            bb = 12'($urandom);
            if ($urandom_range(0, 59) == 0) pv = !pv;
            step(rr, vv, bb, pv);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
